// File: rtl/dht11_ctrl.sv
// dht11_ctrl: DHT11 single-wire sensor controller (start pulse, response handshake, 40-bit frame decode, checksum)
`timescale 1ns/1ps
module dht11_ctrl #(
   parameter int CLK_FREQ_MHZ  = 100,
   parameter int START_LOW_US  = 18000,
   parameter int TIMEOUT_US    = 200,
   parameter int BIT_THRESH_US = 40
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        start,
   input  logic        dht_in,
   output logic        dht_oe,
   output logic        busy,
   output logic [15:0] humidity,
   output logic [15:0] temperature,
   output logic        valid,
   output logic        err_timeout,
   output logic        err_checksum
);
   localparam int PW = CLK_FREQ_MHZ > 1 ? $clog2(CLK_FREQ_MHZ) : 1;
   typedef enum logic [2:0] {IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK} state_t;
   state_t state, state_nxt;
   logic [2:0]    sync;
   logic [PW-1:0] pre;
   logic [15:0]   us;
   logic [5:0]    idx;
   logic [39:0]   sr;
   logic          rise, fall, tick, expired, sum_ok;
   assign rise    = sync[1] & ~sync[2];
   assign fall    = ~sync[1] & sync[2];
   assign tick    = pre == PW'(CLK_FREQ_MHZ - 1);
   assign expired = tick && us == 16'(TIMEOUT_US - 1);
   assign sum_ok  = sr[7:0] == sr[39:32] + sr[31:24] + sr[23:16] + sr[15:8];
   assign busy    = state != IDLE;
   assign dht_oe  = state == START_LOW;
   // next state: follow the line handshake, bail out to IDLE when an expected edge never comes
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = start ? START_LOW : IDLE;
         START_LOW: state_nxt = (tick && us == 16'(START_LOW_US - 1)) ? WAIT_RESP : START_LOW;
         WAIT_RESP: state_nxt = fall ? RESP_LOW : expired ? IDLE : WAIT_RESP;
         RESP_LOW:  state_nxt = rise ? RESP_HIGH : expired ? IDLE : RESP_LOW;
         RESP_HIGH: state_nxt = fall ? BIT_LOW : expired ? IDLE : RESP_HIGH;
         BIT_LOW:   state_nxt = rise ? BIT_HIGH : expired ? IDLE : BIT_LOW;
         BIT_HIGH:  state_nxt = fall ? (idx == 6'd39 ? CHECK : BIT_LOW) : expired ? IDLE : BIT_HIGH;
         default:   state_nxt = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) state <= IDLE;
      else state <= state_nxt;
   // line synchroniser, us timebase restarted on each state change, bit shifter and result registers
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         sync         <= 3'b111;
         pre          <= '0;
         us           <= '0;
         idx          <= '0;
         sr           <= '0;
         humidity     <= '0;
         temperature  <= '0;
         valid        <= 1'b0;
         err_timeout  <= 1'b0;
         err_checksum <= 1'b0;
      end else begin
         sync         <= {sync[1:0], dht_in};
         pre          <= (state_nxt != state || tick) ? '0 : pre + PW'(1);
         us           <= state_nxt != state ? '0 : us + 16'(tick);
         valid        <= state == CHECK && sum_ok;
         err_checksum <= state == CHECK && !sum_ok;
         err_timeout  <= state != IDLE && state != CHECK && state_nxt == IDLE;
         if (state == RESP_HIGH && fall) idx <= '0;
         if (state == BIT_HIGH && fall) begin
            sr  <= {sr[38:0], us > 16'(BIT_THRESH_US)};
            idx <= idx + 6'd1;
         end
         if (state == CHECK && sum_ok) begin
            humidity    <= sr[39:24];
            temperature <= sr[23:8];
         end
      end
endmodule

// File: tb/tb_dht11_ctrl.sv
// tb_dht11_ctrl: directed sensor-frame scenarios against a frame-level model of the controller
`timescale 1ns/1ps
module tb_dht11_ctrl;
   localparam int US = 1000;
   logic        ACLK, ARESETN, start, sen_low, line;
   logic        dht_oe, busy, valid, err_timeout, err_checksum;
   logic [15:0] humidity, temperature;
   logic [15:0] mdl_h, mdl_t, pend_h, pend_t;
   logic        pend_ok, prev_in;
   int          checks, errors, n_valid, n_tmo, n_cks, oe_cnt, tl;

   assign line = !(dht_oe || sen_low);

   dht11_ctrl #(.CLK_FREQ_MHZ(10), .START_LOW_US(20), .TIMEOUT_US(200), .BIT_THRESH_US(40)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .dht_in(line), .dht_oe(dht_oe), .busy(busy),
      .humidity(humidity), .temperature(temperature), .valid(valid),
      .err_timeout(err_timeout), .err_checksum(err_checksum));

   initial ACLK = 1'b0;
   always #50 ACLK = ~ACLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   // per-cycle comparison against the frame-level model
   task automatic monitor();
      if (!ARESETN) begin
         chk("reset_outputs", 64'({dht_oe, busy, valid, err_timeout, err_checksum, humidity, temperature}), 64'(0));
         mdl_h = '0;
         mdl_t = '0;
         oe_cnt = 0;
      end else begin
         chk("pulse_exclusive", 64'(int'(valid) + int'(err_timeout) + int'(err_checksum) < 2), 64'(1));
         chk("oe_implies_busy", 64'(!dht_oe || busy), 64'(1));
         if (valid) begin
            n_valid++;
            chk("valid_expected", 64'(pend_ok), 64'(1));
            mdl_h = pend_h;
            mdl_t = pend_t;
         end
         if (err_checksum) begin
            n_cks++;
            chk("cks_expected", 64'(pend_ok), 64'(0));
         end
         if (err_timeout) begin
            n_tmo++;
            chk("timeout_delay_ok", 64'(tl >= 1995 && tl <= 2015), 64'(1));
         end
         chk("humidity", 64'(humidity), 64'(mdl_h));
         chk("temperature", 64'(temperature), 64'(mdl_t));
         if (dht_oe) oe_cnt++;
         else if (oe_cnt != 0) begin
            chk("oe_low_cycles", 64'(oe_cnt), 64'(200));
            oe_cnt = 0;
         end
      end
      tl = (line != prev_in) ? 0 : tl + 1;
      prev_in = line;
   endtask

   task automatic start_meas();
      int  n = 0;
      bit  saw = 0;
      @(negedge ACLK) start = 1'b1;
      @(negedge ACLK) start = 1'b0;
      while (!dht_oe && n < 10) begin @(negedge ACLK); n++; end
      while (dht_oe && n < 400) begin saw = 1; @(negedge ACLK); n++; end
      chk("start_pulse_seen", 64'(saw && !dht_oe), 64'(1));
   endtask

   // sensor: 5us idle, 20us low, 20us high, then nbits of (5us low, 15us/50us high)
   task automatic sensor(input logic [39:0] f, input int nbits, input int poke);
      #(5*US) sen_low = 1'b1;
      #(20*US) sen_low = 1'b0;
      #(20*US);
      for (int i = 0; i < nbits; i++) begin
         sen_low = 1'b1;
         if (i == poke) begin
            #(US) start = 1'b1;
            #100 start = 1'b0;
            #(4*US - 100);
         end else #(5*US);
         sen_low = 1'b0;
         #((f[39-i] ? 50 : 15) * US);
      end
      sen_low = 1'b1;
      #(5*US);
      if (nbits == 40) sen_low = 1'b0;
   endtask

   task automatic set_model(input logic [39:0] f);
      int s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
      pend_ok = s == int'(f[7:0]);
      pend_h = f[39:24];
      pend_t = f[23:8];
   endtask

   task automatic run(input string nm, input logic [39:0] f, input int nbits, input int poke,
                      input int ev, input int et, input int ec);
      int bv = n_valid, bt = n_tmo, bc = n_cks, n = 0;
      set_model(f);
      start_meas();
      if (nbits >= 0) sensor(f, nbits, poke);
      while (n_valid == bv && n_tmo == bt && n_cks == bc && n < 3000) begin @(negedge ACLK); n++; end
      chk({nm, "_outcome_seen"}, 64'(n < 3000), 64'(1));
      repeat (5) @(negedge ACLK);
      chk({nm, "_valid_pulses"}, 64'(n_valid - bv), 64'(ev));
      chk({nm, "_timeout_pulses"}, 64'(n_tmo - bt), 64'(et));
      chk({nm, "_checksum_pulses"}, 64'(n_cks - bc), 64'(ec));
      chk({nm, "_idle"}, 64'({busy, dht_oe}), 64'(0));
      sen_low = 1'b0;
      repeat (20) @(negedge ACLK);
   endtask

   initial begin
      int bv, bt, bc;
      checks = 0; errors = 0; n_valid = 0; n_tmo = 0; n_cks = 0; oe_cnt = 0; tl = 0;
      ARESETN = 1'b0; start = 1'b0; sen_low = 1'b0; prev_in = 1'b1;
      mdl_h = '0; mdl_t = '0; pend_ok = 1'b0; pend_h = '0; pend_t = '0;
      fork
         forever begin
            @(negedge ACLK);
            monitor();
         end
      join_none
      repeat (5) @(negedge ACLK);
      #20 ARESETN = 1'b1;
      @(negedge ACLK);
      chk("reset_hum_lit", 64'(humidity), 64'h0);
      chk("reset_busy_lit", 64'(busy), 64'h0);
      run("good", 40'h350018004D, 40, -1, 1, 0, 0);
      chk("good_hum_lit", 64'(humidity), 64'h3500);
      chk("good_temp_lit", 64'(temperature), 64'h1800);
      run("badsum", 40'h350018004E, 40, -1, 0, 0, 1);
      chk("badsum_hum_lit", 64'(humidity), 64'h3500);
      chk("badsum_temp_lit", 64'(temperature), 64'h1800);
      run("noresp", 40'h350018004D, -1, -1, 0, 1, 0);
      run("stop13", 40'h1122334477, 13, -1, 0, 1, 0);
      chk("stop13_hum_lit", 64'(humidity), 64'h3500);
      run("after_stop", 40'h2A05190048, 40, -1, 1, 0, 0);
      chk("after_stop_hum_lit", 64'(humidity), 64'h2A05);
      run("poke", 40'h350018004D, 40, 5, 1, 0, 0);
      bv = n_valid; bt = n_tmo; bc = n_cks;
      set_model(40'hFF01800282);
      start_meas();
      sensor(40'hFF01800282, 20, -1);
      @(negedge ACLK);
      #20 ARESETN = 1'b0;
      repeat (5) @(negedge ACLK);
      chk("midreset_busy_lit", 64'(busy), 64'h0);
      chk("midreset_hum_lit", 64'(humidity), 64'h0);
      #20 ARESETN = 1'b1;
      sen_low = 1'b0;
      repeat (20) @(negedge ACLK);
      chk("midreset_no_pulses", 64'((n_valid - bv) + (n_tmo - bt) + (n_cks - bc)), 64'(0));
      run("wrapsum", 40'hFF01800282, 40, -1, 1, 0, 0);
      chk("wrapsum_hum_lit", 64'(humidity), 64'hFF01);
      chk("wrapsum_temp_lit", 64'(temperature), 64'h8002);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
